// File: rtl/dm_jtag_pkg.sv
// Shared JTAG/DTM definitions: TAP state encoding, the DTMCS register layout
// and the default IR codes used by the debug transport TAPs.
package dm_jtag_pkg;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_state_e;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  localparam logic [3:0] DtmVersion        = 4'd1;
  localparam logic [7:0] IrIdcodeDefault   = 8'h01;
  localparam logic [7:0] IrDtmcsDefault    = 8'h10;
  localparam logic [7:0] IrChanBaseDefault = 8'h11;
  localparam logic [7:0] IrCaptureDefault  = 8'h05;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state machine on tms_i plus decoded
// per-state strobes for the surrounding IR/DR logic.
module jtag_tap_fsm
  import dm_jtag_pkg::*;
(
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tms_i,
  output logic test_logic_reset_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TestLogicReset;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    test_logic_reset_o = 1'b0;
    capture_dr_o       = 1'b0;
    shift_dr_o         = 1'b0;
    update_dr_o        = 1'b0;
    capture_ir_o       = 1'b0;
    shift_ir_o         = 1'b0;
    update_ir_o        = 1'b0;
    unique case (state_q)
      TestLogicReset: begin
        test_logic_reset_o = 1'b1;
        state_d = tms_i ? TestLogicReset : RunTestIdle;
      end
      RunTestIdle:  state_d = tms_i ? SelectDrScan : RunTestIdle;
      SelectDrScan: state_d = tms_i ? SelectIrScan : CaptureDr;
      CaptureDr: begin
        capture_dr_o = 1'b1;
        state_d = tms_i ? Exit1Dr : ShiftDr;
      end
      ShiftDr: begin
        shift_dr_o = 1'b1;
        state_d = tms_i ? Exit1Dr : ShiftDr;
      end
      Exit1Dr: state_d = tms_i ? UpdateDr : PauseDr;
      PauseDr: state_d = tms_i ? Exit2Dr : PauseDr;
      Exit2Dr: state_d = tms_i ? UpdateDr : ShiftDr;
      UpdateDr: begin
        update_dr_o = 1'b1;
        state_d = tms_i ? SelectDrScan : RunTestIdle;
      end
      SelectIrScan: state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr: begin
        capture_ir_o = 1'b1;
        state_d = tms_i ? Exit1Ir : ShiftIr;
      end
      ShiftIr: begin
        shift_ir_o = 1'b1;
        state_d = tms_i ? Exit1Ir : ShiftIr;
      end
      Exit1Ir: state_d = tms_i ? UpdateIr : PauseIr;
      PauseIr: state_d = tms_i ? Exit2Ir : PauseIr;
      Exit2Ir: state_d = tms_i ? UpdateIr : ShiftIr;
      UpdateIr: begin
        update_ir_o = 1'b1;
        state_d = tms_i ? SelectDrScan : RunTestIdle;
      end
      default: state_d = TestLogicReset;
    endcase
  end

endmodule

// File: rtl/dmi_jtag_tap_multi.sv
// Debug transport TAP with IDCODE, BYPASS, DTMCS and NumChannels user DR
// channels (channel 0 is the DMI) selected by consecutive IR codes.
module dmi_jtag_tap_multi
  import dm_jtag_pkg::*;
#(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h0000_0001,
  parameter int unsigned NumChannels = 2,
  parameter logic [7:0]  ChanIrBase  = IrChanBaseDefault,
  parameter logic [7:0]  DtmcsIr     = IrDtmcsDefault,
  parameter logic [7:0]  IdcodeIr    = IrIdcodeDefault,
  parameter logic [7:0]  IrCapture   = IrCaptureDefault,
  parameter logic [5:0]  DmiAbits    = 6'd7,
  parameter logic [2:0]  DmiIdle     = 3'd1
) (
  input  logic                   tck_i,
  input  logic                   trst_ni,
  input  logic                   tms_i,
  input  logic                   td_i,
  output logic                   td_o,
  output logic                   tdo_oe_o,
  input  logic                   testmode_i,
  output logic                   test_logic_reset_o,
  output logic                   capture_dr_o,
  output logic                   shift_dr_o,
  output logic                   update_dr_o,
  output logic [NumChannels-1:0] chan_select_o,
  output logic                   chan_tdi_o,
  input  logic [NumChannels-1:0] chan_tdo_i,
  input  logic [1:0]             dmi_error_i,
  output logic                   dmi_reset_o,
  output logic                   dmi_hard_reset_o
);

  localparam int unsigned ExtW = IrLength + 1;

  logic test_logic_reset, capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;

  jtag_tap_fsm i_fsm (
    .tck_i              (tck_i),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .test_logic_reset_o (test_logic_reset),
    .capture_dr_o       (capture_dr),
    .shift_dr_o         (shift_dr),
    .update_dr_o        (update_dr),
    .capture_ir_o       (capture_ir),
    .shift_ir_o         (shift_ir),
    .update_ir_o        (update_ir)
  );

  logic [IrLength-1:0]    ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [31:0]            idcode_q, idcode_d;
  logic                   bypass_q, bypass_d;
  dtmcs_t                 dtmcs_q, dtmcs_d, dtmcs_capture;
  logic                   dmi_reset_q, dmi_reset_d, dmi_hard_reset_q, dmi_hard_reset_d;
  logic                   td_q, tdo_oe_q, tdo_mux;
  logic                   sel_idcode, sel_dtmcs, sel_chan, sel_bypass, chan_tdo_sel;
  logic [ExtW-1:0]        ir_ext, chan_base, chan_off;
  logic [NumChannels-1:0] chan_select;

  // Channel window compared one bit wider than the IR so base+k never wraps.
  assign ir_ext     = {1'b0, ir_q};
  assign chan_base  = ExtW'(ChanIrBase);
  assign chan_off   = ir_ext - chan_base;
  assign sel_idcode = (ir_q == IdcodeIr[IrLength-1:0]);
  assign sel_dtmcs  = !sel_idcode && (ir_q == DtmcsIr[IrLength-1:0]);
  assign sel_chan   = !sel_idcode && !sel_dtmcs && (ir_ext >= chan_base) &&
                      (chan_off < ExtW'(NumChannels));
  assign sel_bypass = !(sel_idcode || sel_dtmcs || sel_chan);

  always_comb begin
    chan_select = '0;
    for (int unsigned k = 0; k < NumChannels; k++) begin
      if (sel_chan && (chan_off == ExtW'(k))) chan_select[k] = 1'b1;
    end
  end

  assign chan_tdo_sel = |(chan_select & chan_tdo_i);

  always_comb begin
    dtmcs_capture         = '0;
    dtmcs_capture.idle    = DmiIdle;
    dtmcs_capture.dmistat = dmi_error_i;
    dtmcs_capture.abits   = DmiAbits;
    dtmcs_capture.version = DtmVersion;
  end

  always_comb begin
    ir_d             = ir_q;
    ir_shift_d       = ir_shift_q;
    idcode_d         = idcode_q;
    bypass_d         = bypass_q;
    dtmcs_d          = dtmcs_q;
    dmi_reset_d      = 1'b0;
    dmi_hard_reset_d = 1'b0;
    if (test_logic_reset) begin
      ir_d       = IdcodeIr[IrLength-1:0];
      ir_shift_d = '0;
      idcode_d   = IdcodeValue;
      bypass_d   = 1'b0;
    end else begin
      if (capture_ir)    ir_shift_d = IrCapture[IrLength-1:0];
      else if (shift_ir) ir_shift_d = {td_i, ir_shift_q[IrLength-1:1]};
      if (update_ir)     ir_d = ir_shift_q;
      if (capture_dr) begin
        if (sel_idcode) idcode_d = IdcodeValue;
        if (sel_bypass) bypass_d = 1'b0;
        if (sel_dtmcs)  dtmcs_d  = dtmcs_capture;
      end else if (shift_dr) begin
        if (sel_idcode) idcode_d = {td_i, idcode_q[31:1]};
        if (sel_bypass) bypass_d = td_i;
        if (sel_dtmcs)  dtmcs_d  = dtmcs_t'({td_i, dtmcs_q[31:1]});
      end
      if (update_dr && sel_dtmcs) begin
        dmi_reset_d      = dtmcs_q.dmireset;
        dmi_hard_reset_d = dtmcs_q.dmihardreset;
      end
    end
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_q             <= IdcodeIr[IrLength-1:0];
      ir_shift_q       <= '0;
      idcode_q         <= IdcodeValue;
      bypass_q         <= 1'b0;
      dtmcs_q          <= '0;
      dmi_reset_q      <= 1'b0;
      dmi_hard_reset_q <= 1'b0;
    end else begin
      ir_q             <= ir_d;
      ir_shift_q       <= ir_shift_d;
      idcode_q         <= idcode_d;
      bypass_q         <= bypass_d;
      dtmcs_q          <= dtmcs_d;
      dmi_reset_q      <= dmi_reset_d;
      dmi_hard_reset_q <= dmi_hard_reset_d;
    end
  end

  always_comb begin
    tdo_mux = bypass_q;
    if (shift_ir)        tdo_mux = ir_shift_q[0];
    else if (sel_idcode) tdo_mux = idcode_q[0];
    else if (sel_dtmcs)  tdo_mux = dtmcs_q[0];
    else if (sel_chan)   tdo_mux = chan_tdo_sel;
  end

  // TDO launches on the falling edge; DFT scan uses the true clock instead.
  logic tck_n, tck_tdo;
  assign tck_n   = ~tck_i;
  assign tck_tdo = testmode_i ? tck_i : tck_n;

  always_ff @(posedge tck_tdo or negedge trst_ni) begin
    if (!trst_ni) begin
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      td_q     <= tdo_mux;
      tdo_oe_q <= shift_ir | shift_dr;
    end
  end

  assign td_o               = td_q;
  assign tdo_oe_o           = tdo_oe_q;
  assign test_logic_reset_o = test_logic_reset;
  assign capture_dr_o       = capture_dr;
  assign shift_dr_o         = shift_dr;
  assign update_dr_o        = update_dr;
  assign chan_select_o      = chan_select;
  assign chan_tdi_o         = td_i;
  assign dmi_reset_o        = dmi_reset_q;
  assign dmi_hard_reset_o   = dmi_hard_reset_q;

endmodule

// File: tb/tb_dmi_jtag_tap_multi.sv
// Scan-level bench: each IR/DR scan is predicted from the register contents
// seen as a bit stream, checked bit by bit, plus a few literal readouts.
module tb_dmi_jtag_tap_multi;

  localparam logic [4:0]  IdcodeIr = 5'h01;
  localparam logic [4:0]  DtmcsIr  = 5'h10;
  localparam logic [4:0]  ChanBase = 5'h11;
  localparam int          NumCh    = 2;
  localparam logic [31:0] IdVal    = 32'h0000_0001;
  localparam logic [4:0]  IrCap    = 5'b00101;

  logic       tck = 1'b0;
  logic       trst_n, tms, td_i, testmode;
  logic [1:0] chan_tdo, dmi_error;
  logic       td_o, tdo_oe, tlr, cap_dr, sh_dr, upd_dr, chan_tdi, dmi_rst, dmi_hrst;
  logic [1:0] chan_sel;

  dmi_jtag_tap_multi dut (
    .tck_i              (tck),
    .trst_ni            (trst_n),
    .tms_i              (tms),
    .td_i               (td_i),
    .td_o               (td_o),
    .tdo_oe_o           (tdo_oe),
    .testmode_i         (testmode),
    .test_logic_reset_o (tlr),
    .capture_dr_o       (cap_dr),
    .shift_dr_o         (sh_dr),
    .update_dr_o        (upd_dr),
    .chan_select_o      (chan_sel),
    .chan_tdi_o         (chan_tdi),
    .chan_tdo_i         (chan_tdo),
    .dmi_error_i        (dmi_error),
    .dmi_reset_o        (dmi_rst),
    .dmi_hard_reset_o   (dmi_hrst)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_ir;
  logic last_rst, last_hrst;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One TCK cycle; outputs are sampled just after the falling edge.
  task automatic step(input logic t, input logic d);
    tms  = t;
    td_i = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  function automatic int chan_of(input logic [4:0] ir);
    if (ir == IdcodeIr || ir == DtmcsIr) return -1;
    if (int'(ir) >= int'(ChanBase) && int'(ir) < int'(ChanBase) + NumCh)
      return int'(ir) - int'(ChanBase);
    return -1;
  endfunction

  function automatic logic [1:0] exp_sel(input logic [4:0] ir);
    int c;
    c = chan_of(ir);
    return (c >= 0) ? 2'(1 << c) : 2'b00;
  endfunction

  function automatic int dr_len(input logic [4:0] ir);
    return (ir == IdcodeIr || ir == DtmcsIr) ? 32 : 1;
  endfunction

  function automatic logic [31:0] dr_cap(input logic [4:0] ir, input logic [1:0] err);
    if (ir == IdcodeIr) return IdVal;
    if (ir == DtmcsIr) return 32'd1 + (32'd7 << 4) + (32'(err) << 10) + (32'd1 << 12);
    return 32'd0;
  endfunction

  task automatic scan_ir(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic [127:0] stream;
    stream = (128'(din) << 5) | 128'(IrCap);
    dout = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      check("ir_tdo", 64'(td_o), 64'(stream[i]));
      check("ir_oe", 64'(tdo_oe), 64'd1);
      dout[i] = td_o;
      step(i == n - 1, din[i]);
    end
    check("ir_oe_off", 64'(tdo_oe), 64'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    exp_ir = stream[n +: 5];
    check("chan_select", 64'(chan_sel), 64'(exp_sel(exp_ir)));
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic [127:0] stream;
    logic [31:0]  fin;
    int           ch, len;
    ch     = chan_of(exp_ir);
    len    = dr_len(exp_ir);
    stream = (128'(din) << len) | 128'(dr_cap(exp_ir, dmi_error));
    dout   = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("capture_dr", 64'(cap_dr), 64'd1);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      check("dr_tdo", 64'(td_o), (ch >= 0) ? 64'(chan_tdo[ch]) : 64'(stream[i]));
      check("dr_oe", 64'(tdo_oe), 64'd1);
      check("shift_dr", 64'(sh_dr), 64'd1);
      check("pulse_in_shift", 64'({dmi_rst, dmi_hrst}), 64'd0);
      check("chan_sel_shift", 64'(chan_sel), 64'(exp_sel(exp_ir)));
      dout[i] = td_o;
      step(i == n - 1, din[i]);
    end
    check("dr_oe_off", 64'(tdo_oe), 64'd0);
    step(1'b1, 1'b0);
    check("update_dr", 64'(upd_dr), 64'd1);
    check("pulse_in_update", 64'({dmi_rst, dmi_hrst}), 64'd0);
    step(1'b0, 1'b0);
    fin = stream[n +: 32];
    last_rst  = dmi_rst;
    last_hrst = dmi_hrst;
    check("dmi_reset", 64'(dmi_rst), (exp_ir == DtmcsIr) ? 64'(fin[16]) : 64'd0);
    check("dmi_hard_reset", 64'(dmi_hrst), (exp_ir == DtmcsIr) ? 64'(fin[17]) : 64'd0);
    step(1'b0, 1'b0);
    check("pulse_one_cycle", 64'({dmi_rst, dmi_hrst}), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] dout;
    logic [4:0]  code;
    trst_n = 1'b0; tms = 1'b1; td_i = 1'b0; testmode = 1'b0;
    chan_tdo = 2'b00; dmi_error = 2'b00;
    exp_ir = IdcodeIr;
    last_rst = 1'b0; last_hrst = 1'b0;
    #12;
    check("rst_tlr", 64'(tlr), 64'd1);
    check("rst_td_o", 64'({td_o, tdo_oe}), 64'd0);
    check("rst_chan_sel", 64'(chan_sel), 64'd0);
    check("rst_pulses", 64'({dmi_rst, dmi_hrst}), 64'd0);
    @(negedge tck); #1;
    trst_n = 1'b1;
    repeat (5) step(1'b1, 1'b0);
    check("tlr_after_tms", 64'(tlr), 64'd1);
    step(1'b0, 1'b0);

    scan_dr(32, 64'h0, dout);
    check("idcode_readout", 64'(dout[31:0]), 64'h0000_0001);

    scan_ir(5, 64'h1F, dout);
    check("ir_capture_bits", 64'(dout[4:0]), 64'h05);
    scan_dr(9, 64'hA5, dout);
    check("bypass_delay", 64'(dout[8:0]), 64'h14A);

    scan_ir(5, 64'h10, dout);
    dmi_error = 2'b10;
    scan_dr(32, 64'h0003_0000, dout);
    check("dtmcs_readout", 64'(dout[31:0]), 64'h0000_1871);
    check("both_pulses", 64'({last_rst, last_hrst}), 64'h3);
    scan_dr(32, 64'h0001_0000, dout);
    check("reset_only_pulse", 64'({last_rst, last_hrst}), 64'h2);

    scan_ir(5, 64'h12, dout);
    check("chan1_select", 64'(chan_sel), 64'h2);
    chan_tdo = 2'b10;
    scan_dr(8, 64'h3C, dout);
    check("chan1_readout", 64'(dout[7:0]), 64'hFF);
    td_i = 1'b1; #1;
    check("chan_tdi", 64'(chan_tdi), 64'd1);
    scan_ir(5, 64'h13, dout);
    check("ir13_select", 64'(chan_sel), 64'h0);
    scan_dr(3, 64'h5, dout);
    check("ir13_bypass", 64'(dout[2:0]), 64'h2);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 7))
        0: code = IdcodeIr;
        1: code = DtmcsIr;
        2: code = 5'h11;
        3: code = 5'h12;
        4: code = 5'h13;
        5: code = 5'h00;
        6: code = 5'h1F;
        default: code = 5'($urandom);
      endcase
      scan_ir(5, 64'(code), dout);
      dmi_error = 2'($urandom);
      chan_tdo  = 2'($urandom);
      scan_dr($urandom_range(1, 40), {$urandom, $urandom}, dout);
      if ($urandom_range(0, 3) == 0) begin
        repeat (5) step(1'b1, 1'b0);
        check("tlr_random", 64'(tlr), 64'd1);
        step(1'b0, 1'b0);
        exp_ir = IdcodeIr;
      end
    end

    scan_ir(5, 64'h10, dout);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b1);
    trst_n = 1'b0;
    #2;
    check("trst_tlr", 64'(tlr), 64'd1);
    check("trst_td_o", 64'({td_o, tdo_oe}), 64'd0);
    check("trst_chan_sel", 64'(chan_sel), 64'd0);
    @(negedge tck); #1;
    trst_n = 1'b1;
    step(1'b0, 1'b0);
    check("trst_no_pulse", 64'({dmi_rst, dmi_hrst}), 64'd0);
    exp_ir = IdcodeIr;
    scan_dr(32, 64'h0, dout);
    check("trst_ir_idcode", 64'(dout[31:0]), 64'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmi_jtag_tap_multi.md
Name: dmi_jtag_tap_multi

Overview:
Parametrised JTAG TAP that serves the debug transport module (DTM). It supports IDCODE, BYPASS and DTMCS, plus NumChannels user DR channels selected by consecutive IR codes; channel 0 is the DMI.
It extends the single-DMI TAP in four ways: configurable IR length and capture pattern; DTMCS fields driven from parameters; dmireset and dmihardreset as one-cycle pulses raised on Update-DR; a proper 32-bit DTMCS shift path.
It sits between the JTAG pads and the dmi_jtag / user-DR shift logic.

Parameters:
IrLength, 5, IR width; legal range 4..8.
IdcodeValue, 32'h00000001, IDCODE content; bit 0 must be 1.
NumChannels, 2, number of user DR channels; legal range 1..8.
ChanIrBase, 'h11, IR code of channel 0; channel k is selected by ChanIrBase+k.
DtmcsIr, 'h10, IR code selecting DTMCS.
IdcodeIr, 'h01, IR code selecting IDCODE.
IrCapture, 'b00101, value loaded into the IR shift register in Capture-IR; bits[1:0] must be 2'b01.
DmiAbits, 7, DTMCS.abits field.
DmiIdle, 1, DTMCS.idle field.

Ports:
tck_i  in  1  JTAG clock; the only clock.
trst_ni  in  1  asynchronous active-low reset.
tms_i  in  1  test mode select.
td_i  in  1  test data in.
td_o  out  1  test data out; changes on the falling edge of tck_i.
tdo_oe_o  out  1  TDO output enable.
testmode_i  in  1  DFT: selects the non-inverted tck_i for the TDO flops.
test_logic_reset_o  out  1  high while in Test-Logic-Reset.
capture_dr_o  out  1  high in Capture-DR.
shift_dr_o  out  1  high in Shift-DR.
update_dr_o  out  1  high in Update-DR.
chan_select_o  out  NumChannels  one-hot channel select decoded from the IR.
chan_tdi_o  out  1  td_i forwarded to the channels.
chan_tdo_i  in  NumChannels  serial data returned by each channel.
dmi_error_i  in  2  dmistat value sampled in Capture-DR.
dmi_reset_o  out  1  one-tck pulse: DTMCS dmireset.
dmi_hard_reset_o  out  1  one-tck pulse: DTMCS dmihardreset.

Behaviour:
- All sequential state is on the rising edge of tck_i, with trst_ni async active-low. TDO flops use the inverted tck_i, or tck_i itself when testmode_i=1, built from the existing clock inverter and clock mux cells.
- Reset values:
  - tap state = TestLogicReset; IR = IdcodeIr; IR shift register = 0.
  - idcode register = IdcodeValue; bypass = 0; dtmcs register = 0.
  - td_o = 0, tdo_oe_o = 0, dmi_reset_o = 0, dmi_hard_reset_o = 0.
  - chan_select_o = 0.
- FSM: the standard 16-state IEEE 1149.1 TAP, transitions on tms_i. Five consecutive tms_i=1 cycles reach TestLogicReset from any state.
- test_logic_reset_o, capture_dr_o, shift_dr_o and update_dr_o are combinational decodes of the current state.
- TestLogicReset is a synchronous reset of the instruction: IR = IdcodeIr, IR shift = 0, idcode register = IdcodeValue, bypass = 0.
- IR path:
  - Capture-IR loads IrCapture.
  - Shift-IR shifts right, td_i entering the MSB; TDO = shift[0].
  - Update-IR copies the shift register into the IR.
- Decode (priority order):
  - IR==IdcodeIr selects IDCODE.
  - IR==DtmcsIr selects DTMCS.
  - ChanIrBase <= IR < ChanIrBase+NumChannels selects channel IR-ChanIrBase.
  - All other codes, including all-0 and all-1, select BYPASS.
  - The IR arithmetic is unsigned at IrLength+1 bits, so there is no wrap-around.
- DR path:
  - IDCODE: captures IdcodeValue; shifts 32 bits LSB first.
  - BYPASS: captures 0; 1-bit delay.
  - DTMCS: Capture-DR loads {14'b0, 0, 0, 0, DmiIdle[2:0], dmi_error_i, DmiAbits[5:0], 4'd1}. It then shifts 32 bits LSB first; TDO = dtmcs_q[0].
  - Channel k: TDO = chan_tdo_i[k]; the channel owns its own register.
- Reset pulses: in Update-DR with DTMCS selected, the cycle after Update-DR drives:
  - dmi_reset_o = dtmcs_q[16];
  - dmi_hard_reset_o = dtmcs_q[17];
  - each for exactly one tck; both may assert together.
  - Pulses are registered, never level-held during Shift-DR.
- TDO: registered on the falling edge of tck_i. td_o = the mux output; tdo_oe_o = shift_ir | shift_dr.
- An IR update never changes chan_select_o during Shift-DR, because the IR only changes in Update-IR.
- trst_ni asserted mid-shift: all state returns to reset values immediately, and in-flight pulses are dropped.

Decomposition:
- Package dm_jtag_pkg holds:
  - the tap_state_e enum (16 states);
  - the dtmcs_t packed struct;
  - DTM version constant 4'd1;
  - the default IR code constants.
- Sub-module jtag_tap_fsm: the state register, next-state logic and state-decode strobes. It is reusable by other TAPs in the codebase.

Test Plan:
- Reset, then 5x TMS=1, then RTI, then shift 32 DR bits -> td_o sequence equals 32'h00000001 LSB first; tdo_oe_o=1 only during shifts.
- Shift-IR with td_i=1 on all 5 bits -> first 5 TDO bits are 1,0,1,0,0 (IrCapture LSB first); then DR shift of 0xA5 -> the same bits return delayed by 1 (BYPASS).
- IR=0x10 with dmi_error_i=2'b10 -> DTMCS readout = 32'h00001871.
- IR=0x10, shift a DR with bits 16 and 17 set -> dmi_reset_o and dmi_hard_reset_o each high exactly one tck after Update-DR; with bit 16 only, dmi_hard_reset_o stays 0.
- NumChannels=2: IR=0x12 -> chan_select_o=2'b10 and TDO follows chan_tdo_i[1]; IR=0x13 -> BYPASS with chan_select_o=0.
- trst_ni pulsed low mid Shift-DR -> state TestLogicReset, IR=IdcodeIr, td_o=0, no pulse output.
